// File: rtl/onchip_rd_pkg.sv
// Shared types and defaults for the on-chip RAM read master and its output FIFO.
package onchip_rd_pkg;

    localparam int DEF_ADDR_W     = 14;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LEN_W      = 15;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/onchip_rd_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data always shows the head entry.
module onchip_rd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/nios_system_onchip_reader.sv
// Avalon-MM read master: streams `length` words from on-chip RAM (1-cycle read latency)
// through a credit-checked FIFO so downstream backpressure never overflows it.
module nios_system_onchip_reader
    import onchip_rd_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] last_addr_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              done_q, done_d;

    logic              issue;
    logic              issue_final;
    logic              credit_ok;
    logic [CNT_W:0]    occupancy;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W:0]   fifo_head;

    // Words already in the FIFO plus the one on the bus must leave room for another read.
    assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok   = !fifo_full && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign issue_final = issue && (remaining_q == LEN_W'(1));
    assign fifo_pop    = src_valid && src_ready;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        cur_addr_d  = base_addr;
                        remaining_d = length;
                        state_d     = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The tagged word leaving the FIFO is necessarily the final one of the transfer.
                if (fifo_pop && src_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cur_addr_q      <= '0;
            remaining_q     <= '0;
            last_addr_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_final;
            done_q          <= done_d;
            if (issue) begin
                last_addr_q <= cur_addr_q;
            end
        end
    end

    onchip_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight_q),
        .wr_data ({inflight_last_q, m_readdata}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign m_chipselect = issue;
    assign m_address    = issue ? cur_addr_q : last_addr_q;
    assign m_write      = 1'b0;
    assign m_byteenable = 4'hF;

    // Head contents are masked while empty so the stream outputs read 0 rather than stale RAM.
    assign src_valid = !fifo_empty;
    assign src_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign src_last  = !fifo_empty && fifo_head[DATA_W];

endmodule

// File: tb/tb_nios_system_onchip_reader.sv
// Bench for nios_system_onchip_reader: directed and randomized transfers against an arithmetic model.
module tb_nios_system_onchip_reader;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 15;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic [DATA_W-1:0] m_readdata;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_last;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    nios_system_onchip_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_readdata   (m_readdata),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_last     (src_last)
    );

    // RAM contents mem[i] = i ^ 0xA5A5_0000, returned one clock after the strobe.
    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        return {18'h0, a} ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) begin
        if (m_chipselect) m_readdata <= ram_word(m_address);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
        check({tag, "_addr"},  64'(m_address), 64'(0));
        check({tag, "_cs"},    64'(m_chipselect), 64'(0));
        check({tag, "_wr"},    64'(m_write), 64'(0));
        check({tag, "_be"},    64'(m_byteenable), 64'hF);
        check({tag, "_data"},  64'(src_data), 64'(0));
        check({tag, "_valid"}, 64'(src_valid), 64'(0));
        check({tag, "_last"},  64'(src_last), 64'(0));
    endtask

    // mode: 0 ready held high, 1 ready toggling, 2 ready random.
    task automatic run_xfer(input string tag, input logic [ADDR_W-1:0] base, input int len,
                            input int mode, input int inject_at, input int abort_after,
                            input bit chk_timing);
        logic [DATA_W-1:0] got_data[$];
        bit                got_last[$];
        logic [ADDR_W-1:0] got_addr[$];
        int first_hs = -1;
        int last_hs  = -1;
        int done_at  = -1;
        int busy_bad = 0;
        int max_cnt  = 0;
        int limit;
        int n;
        bit busy_at_done = 1'b0;
        bit aborted = 1'b0;
        logic [ADDR_W-1:0] exp_addr;

        limit     = 20 * len + 40;
        base_addr = base;
        length    = LEN_W'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < limit; i++) begin
            case (mode)
                0:       src_ready = 1'b1;
                1:       src_ready = (i % 2 == 0);
                default: src_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (i == inject_at) begin
                start     = 1'b1;
                base_addr = base + 14'h100;
                length    = LEN_W'(len + 3);
            end else begin
                start = 1'b0;
            end
            if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
            if (m_chipselect) got_addr.push_back(m_address);
            if (src_valid && src_ready) begin
                if (first_hs < 0) first_hs = i;
                last_hs = i;
                got_data.push_back(src_data);
                got_last.push_back(src_last);
            end
            if (done) begin
                done_at      = i;
                busy_at_done = busy;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (abort_after > 0 && got_data.size() == abort_after) begin
                aborted = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (aborted) return;

        check({tag, "_done_seen"}, 64'(done_at >= 0), 64'(1));
        check({tag, "_nwords"}, 64'(got_data.size()), 64'(len));
        check({tag, "_nissue"}, 64'(got_addr.size()), 64'(len));
        n = (got_data.size() < len) ? got_data.size() : len;
        for (int k = 0; k < n; k++) begin
            exp_addr = base + ADDR_W'(k);
            check($sformatf("%s_d%0d", tag, k), 64'(got_data[k]), 64'(ram_word(exp_addr)));
            check($sformatf("%s_l%0d", tag, k), 64'(got_last[k]), 64'(k == len - 1));
        end
        n = (got_addr.size() < len) ? got_addr.size() : len;
        for (int k = 0; k < n; k++) begin
            exp_addr = base + ADDR_W'(k);
            check($sformatf("%s_a%0d", tag, k), 64'(got_addr[k]), 64'(exp_addr));
        end
        check({tag, "_done_lat"}, 64'(done_at), 64'((len == 0) ? 0 : last_hs + 1));
        check({tag, "_busy"}, 64'(busy_bad), 64'(0));
        check({tag, "_busy_done"}, 64'(busy_at_done), 64'(0));
        check({tag, "_fifo_max"}, 64'(max_cnt <= FIFO_DEPTH), 64'(1));
        if (chk_timing) begin
            check({tag, "_first"}, 64'(first_hs), 64'(2));
            check({tag, "_b2b"}, 64'(last_hs - first_hs), 64'(len - 1));
        end
    endtask

    initial begin
        bit done_seen;
        bit cs_seen;

        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        length     = '0;
        src_ready  = 1'b0;
        m_readdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_xfer("seq8",  14'h0010,  8, 0, -1, 0, 1'b1);
        run_xfer("wrap4", 14'h3FFE,  4, 0, -1, 0, 1'b0);
        run_xfer("tog20", 14'h0200, 20, 1, -1, 0, 1'b0);
        run_xfer("len0",  14'h0123,  0, 0, -1, 0, 1'b0);
        run_xfer("ignst", 14'h0040, 12, 0,  3, 0, 1'b0);

        run_xfer("abort", 14'h0080, 10, 0, -1, 5, 1'b0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        reset_n   = 1'b1;
        done_seen = 1'b0;
        cs_seen   = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) done_seen = 1'b1;
            if (m_chipselect) cs_seen = 1'b1;
        end
        check("midrst_nodone", 64'(done_seen), 64'(0));
        check("midrst_nocs", 64'(cs_seen), 64'(0));
        check("midrst_idle", 64'(busy), 64'(0));
        run_xfer("postrst", 14'h0300, 6, 0, -1, 0, 1'b1);

        for (int t = 0; t < 12; t++) begin
            run_xfer($sformatf("rnd%0d", t), 14'($urandom), int'($urandom_range(0, 40)), 2, -1, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
